// File: rtl/div16_seq.sv
// Purpose : iterative restoring divider, one quotient bit per cycle, unsigned or signed.
// Latency : start accepted at edge N -> busy cycles N+1..N+16, done in cycle N+17;
//           divisor == 0 short-circuits to done in cycle N+1.
// Backpressure: none; start is only sampled in IDLE and ignored while busy or done.
//
// Optional feature macro: DIV16_SIGNED_EN (signed_op honoured only when defined).
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      synchronous active-low reset
//   start      begin a divide (sampled in IDLE only)
//   signed_op  1 = two's-complement divide (needs DIV16_SIGNED_EN), 0 = unsigned
//   dividend   numerator, captured on start acceptance
//   divisor    denominator, captured on start acceptance
//   busy       high while iterating
//   done       one-cycle pulse; results valid from this cycle on
//   quotient   result quotient (held until next done or reset)
//   remainder  result remainder (held until next done or reset)
//   div_zero   last accepted operation had divisor == 0
module div16_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [4:0]       cnt;
    logic [WIDTH-1:0] rem_q;     // running partial remainder
    logic [WIDTH-1:0] dq_q;      // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] dvs_q;     // captured divisor magnitude

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] dq_step;
    logic             last_step;
    logic             accept;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] q_final;
    logic [WIDTH-1:0] r_final;

`ifdef DIV16_SIGNED_EN
    logic neg_q;   // operand signs differ -> negate quotient
    logic neg_r;   // negative dividend -> negate remainder (truncation toward zero)
    logic a_neg;
    logic b_neg;

    assign a_neg = signed_op & dividend[WIDTH-1];
    assign b_neg = signed_op & divisor[WIDTH-1];
    assign a_mag = a_neg ? (~dividend + 1'b1) : dividend;
    assign b_mag = b_neg ? (~divisor + 1'b1) : divisor;
    // 0x8000 negates to itself and is treated as magnitude 32768, which the
    // unsigned core handles correctly; 0x8000/0xFFFF therefore yields 0x8000.
    assign q_final = neg_q ? (~dq_step + 1'b1) : dq_step;
    assign r_final = neg_r ? (~rem_step + 1'b1) : rem_step;
`else
    logic unused_signed_op;

    assign unused_signed_op = signed_op;
    assign a_mag   = dividend;
    assign b_mag   = divisor;
    assign q_final = dq_step;
    assign r_final = rem_step;
`endif

    // One restoring step: bring in the next dividend bit, trial-subtract,
    // keep the difference only when it did not borrow.
    assign partial   = {rem_q, dq_q[WIDTH-1]};
    assign diff      = partial - {1'b0, dvs_q};
    assign qbit      = ~diff[WIDTH];
    assign rem_step  = qbit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
    assign dq_step   = {dq_q[WIDTH-2:0], qbit};
    assign last_step = (cnt == 5'(WIDTH - 1));
    assign accept    = (state == IDLE) && start;

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (divisor == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem_q     <= '0;
            dq_q      <= '0;
            dvs_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
`ifdef DIV16_SIGNED_EN
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (accept) begin
                if (divisor == '0) begin
                    // Raw operand bits, regardless of signed_op.
                    div_zero  <= 1'b1;
                    quotient  <= '1;
                    remainder <= dividend;
                end else begin
                    div_zero <= 1'b0;
                    rem_q    <= '0;
                    dq_q     <= a_mag;
                    dvs_q    <= b_mag;
                    cnt      <= '0;
`ifdef DIV16_SIGNED_EN
                    neg_q    <= a_neg ^ b_neg;
                    neg_r    <= a_neg;
`endif
                end
            end else if (state == RUN) begin
                rem_q <= rem_step;
                dq_q  <= dq_step;
                // Stops at WIDTH after the final step, so it never wraps.
                cnt   <= cnt + 5'd1;
                if (last_step) begin
                    quotient  <= q_final;
                    remainder <= r_final;
                end
            end
        end
    end

endmodule

// File: doc/div16_seq.md
DIV16_SEQ -- requirements
Module: div16_seq

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand and result width in bits; supported value is 16 only.
REQ-002 The block SHALL have the following ports:
- clk  input  1  the single clock; all state changes on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- start  input  1  request to begin a divide; sampled only in IDLE.
- signed_op  input  1  1 = two's-complement divide, 0 = unsigned.
- dividend  input  16  numerator; captured when start is accepted.
- divisor  input  16  denominator; captured when start is accepted.
- busy  output  1  high while the block is in RUN.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- quotient  output  16  result quotient.
- remainder  output  16  result remainder.
- div_zero  output  1  last accepted operation had divisor == 0.

Function
REQ-003 The block SHALL implement the FSM states IDLE, RUN and DONE, using an iterative restoring algorithm: one shift/subtract/restore step per cycle in RUN.
REQ-004 IDLE with start=1 and divisor!=0 at edge N SHALL:
- capture the operands and clear div_zero;
- enter RUN for exactly 16 cycles (N+1..N+16);
- enter DONE with done=1 during cycle N+17;
- return to IDLE at the following edge.
REQ-005 IDLE with start=1 and divisor==0 SHALL go directly to DONE with div_zero=1, quotient=16'hFFFF and remainder=dividend; done is high in cycle N+1 and no RUN cycles occur.
REQ-006 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE and never for more than one cycle per accepted start.
REQ-007 start SHALL be ignored in RUN and DONE; a start held high SHALL be accepted again on the first IDLE cycle after DONE.
REQ-008 quotient, remainder and div_zero SHALL update only on entry to DONE and SHALL hold their values until the next DONE or until reset.
REQ-009 Each iteration SHALL form a 17-bit partial remainder (shifted remainder concatenated with the next dividend bit) minus the zero-extended divisor:
- if the result is non-negative, keep the difference and set quotient bit = 1;
- otherwise keep the unmodified partial remainder and set quotient bit = 0.
REQ-010 Unsigned results SHALL satisfy dividend == quotient*divisor + remainder, with remainder < divisor; for example, 0xFFFF/0x0001 gives quotient 0xFFFF and remainder 0.
REQ-011 An internal 5-bit iteration counter SHALL load 0 on start acceptance, increment each RUN cycle, and leave RUN after the step at count 15; it SHALL never wrap.

Reset
REQ-012 With rst_n=0 at a rising edge, the block SHALL go to IDLE and clear busy, done, quotient, remainder, div_zero and the iteration counter to 0.
REQ-013 Reset asserted in RUN or DONE SHALL abort the operation with no done pulse; start SHALL be ignored in any cycle where rst_n=0.

Configuration
REQ-014 Macro DIV16_SIGNED_EN SHALL control signed support.
REQ-015 With DIV16_SIGNED_EN defined and signed_op=1, the block SHALL:
- divide the operand magnitudes;
- negate the quotient if the operand signs differ;
- give the remainder the sign of the dividend (truncation toward zero);
- return quotient 0x8000 and remainder 0 for 0x8000/0xFFFF;
- use the same latency as unsigned.
REQ-016 Without DIV16_SIGNED_EN, signed_op SHALL be ignored and all operations SHALL be unsigned; no sign/negation logic is synthesized.
REQ-017 The divide-by-zero results of REQ-005 SHALL apply in both configurations, using raw operand bits.

Verification
REQ-018 Basic divide: start at edge N with 100/7 -> busy cycles N+1..N+16; done in cycle N+17 only; quotient=14, remainder=2, div_zero=0.
REQ-019 Divide by zero: 0x1234/0 -> done in cycle N+1; div_zero=1, quotient=0xFFFF, remainder=0x1234; busy never high.
REQ-020 Start while busy: pulse start with 5/1 in the 8th RUN cycle of 100/7 -> ignored; result 14/2; exactly one done pulse.
REQ-021 Reset mid-operation: rst_n=0 in the 5th RUN cycle -> next cycle all outputs 0 and IDLE; a subsequent 9/3 -> quotient 3, remainder 0 after 17 cycles.
REQ-022 Signed (macro defined), signed_op=1:
- 0xFFF9/0x0002 (-7/2) -> quotient 0xFFFD, remainder 0xFFFF;
- 0x8000/0xFFFF -> quotient 0x8000, remainder 0.
REQ-023 Back-to-back: start held high for 40 cycles with 0xFFFF/0x0010 -> done pulses in cycles N+17 and N+35, each with quotient 0x0FFF and remainder 0x000F.
